// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one sdram wrapper port among NUM_CLIENTS level-handshake requesters.
// Turns held client requests into single-cycle mem_wr/mem_rd pulses, with a watchdog on mem_ready.
module sdram_port_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int ADDR_WIDTH     = 31,
  parameter int DATA_WIDTH     = 32,
  parameter int DQM_WIDTH      = 4,
  parameter int BURST_WIDTH    = 128,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CLIENTS-1:0]                  client_req,
  input  logic [NUM_CLIENTS-1:0]                  client_we,
  input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0]  client_addr,
  input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]  client_data,
  input  logic [NUM_CLIENTS-1:0][DQM_WIDTH-1:0]   client_be,
  output logic [NUM_CLIENTS-1:0]                  client_ack,
  output logic                                    client_err,
  output logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]  client_q,
  output logic [NUM_CLIENTS-1:0][BURST_WIDTH-1:0] client_q_burst,
  output logic [ADDR_WIDTH-1:0]                   mem_addr,
  output logic [DATA_WIDTH-1:0]                   mem_data,
  output logic [DQM_WIDTH-1:0]                    mem_be,
  output logic                                    mem_wr,
  output logic                                    mem_rd,
  input  logic                                    mem_available,
  input  logic                                    mem_ready,
  input  logic [DATA_WIDTH-1:0]                   mem_q,
  input  logic [BURST_WIDTH-1:0]                  mem_q_burst,
  output logic                                    busy
);

  localparam int          IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned N     = NUM_CLIENTS;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       rr_last;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       pick;
  logic                   found;
  logic                   we_latched;
  logic [CNT_W-1:0]       count;
  logic [NUM_CLIENTS-1:0] acked_last;
  logic [NUM_CLIENTS-1:0] eligible;

  // A client still holding req right after its ack sits out one arbitration.
  assign eligible = client_req & ~acked_last;
  assign busy     = (state != IDLE);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = rr_last;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(rr_last) + k) % N;
      if (!found && eligible[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_last        <= IDX_W'(NUM_CLIENTS - 1);
      grant          <= '0;
      we_latched     <= 1'b0;
      count          <= '0;
      acked_last     <= '0;
      client_ack     <= '0;
      client_err     <= 1'b0;
      client_q       <= '0;
      client_q_burst <= '0;
      mem_addr       <= '0;
      mem_data       <= '0;
      mem_be         <= '0;
      mem_wr         <= 1'b0;
      mem_rd         <= 1'b0;
    end else begin
      acked_last <= client_ack;
      client_ack <= '0;
      client_err <= 1'b0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_available && found) begin
            grant      <= pick;
            rr_last    <= pick;
            mem_addr   <= client_addr[pick];
            mem_data   <= client_data[pick];
            mem_be     <= client_be[pick];
            we_latched <= client_we[pick];
            mem_wr     <= client_we[pick];
            mem_rd     <= ~client_we[pick];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // mem_ready takes priority over an expiring watchdog in the same cycle.
          if (mem_ready) begin
            if (!we_latched) begin
              client_q[grant]       <= mem_q;
              client_q_burst[grant] <= mem_q_burst;
            end
            client_ack[grant] <= 1'b1;
            state             <= RECOVER;
          end else if (count == CNT_W'(TIMEOUT_CYCLES)) begin
            client_ack[grant] <= 1'b1;
            client_err        <= 1'b1;
            state             <= RECOVER;
          end else begin
            count <= count + 1'b1;
          end
        end
        RECOVER: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus queues expected issues/acks, monitor compares.
module tb_sdram_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 31;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int QW  = 128;
  localparam int TMO = 1023;
  localparam int LAT = 2;
  localparam logic [AW-1:0] BAD = 31'h0000BAD0;

  logic                   clk, reset;
  logic [N-1:0]           client_req, client_we, client_ack;
  logic [N-1:0][AW-1:0]   client_addr;
  logic [N-1:0][DW-1:0]   client_data, client_q;
  logic [N-1:0][BEW-1:0]  client_be;
  logic [N-1:0][QW-1:0]   client_q_burst;
  logic                   client_err;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_data, mem_q;
  logic [BEW-1:0]         mem_be;
  logic                   mem_wr, mem_rd, mem_available, mem_ready, busy;
  logic [QW-1:0]          mem_q_burst;

  sdram_port_arbiter #(
    .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DQM_WIDTH(BEW),
    .BURST_WIDTH(QW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .client_req(client_req), .client_we(client_we), .client_addr(client_addr),
    .client_data(client_data), .client_be(client_be), .client_ack(client_ack),
    .client_err(client_err), .client_q(client_q), .client_q_burst(client_q_burst),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_available(mem_available), .mem_ready(mem_ready),
    .mem_q(mem_q), .mem_q_burst(mem_q_burst), .busy(busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BEW-1:0] be;
  } iss_t;
  typedef struct {
    int unsigned   cl;
    logic          err;
    logic [DW-1:0] q;
    logic [QW-1:0] burst;
  } ack_t;

  iss_t issq[$];
  ack_t ackq[$];

  int unsigned passed = 0, total = 0;
  int unsigned cyc = 0;
  int unsigned ready_cyc = 0, issue_cyc = 0;
  int unsigned target[N], done[N];
  int unsigned stray_req = 0, stray_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [QW-1:0] mk_burst(input logic [DW-1:0] q);
    return {q, ~q, q ^ 32'h0F0F0F0F, q};
  endfunction

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_iss(input int unsigned c);
    iss_t e;
    e.we = client_we[c]; e.addr = client_addr[c]; e.data = client_data[c]; e.be = client_be[c];
    issq.push_back(e);
  endtask

  task automatic push_ack(input int unsigned c, input logic err, input logic [DW-1:0] q,
                          input logic [QW-1:0] burst);
    ack_t e;
    e.cl = c; e.err = err; e.q = q; e.burst = burst;
    ackq.push_back(e);
  endtask

  task automatic set_client(input int unsigned c, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [BEW-1:0] be);
    client_we[c] = we; client_addr[c] = addr; client_data[c] = data; client_be[c] = be;
  endtask

  function automatic logic all_done();
    logic d;
    d = (issq.size() == 0) && (ackq.size() == 0) && !busy;
    for (int i = 0; i < N; i++) if (target[i] != done[i]) d = 1'b0;
    return d;
  endfunction

  task automatic wait_done(input int unsigned limit, input string name);
    int unsigned n;
    n = 0;
    while (!all_done() && n < limit) begin
      step(1);
      n++;
    end
    chk(name, 128'(n < limit), 128'(1));
  endtask

  // Client model: holds req while it still has requests outstanding.
  initial begin
    client_req = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (client_ack[i]) done[i]++;
        client_req[i] = (target[i] != done[i]);
      end
    end
  end

  // Memory model: answers LAT cycles after a pulse, never answers BAD, can emit a stray ready.
  initial begin
    int unsigned cd;
    logic [DW-1:0] rsp;
    cd = 0; rsp = '0;
    mem_ready = 1'b0; mem_q = '0; mem_q_burst = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (cd != 0) begin
        cd--;
        if (cd == 0) begin
          mem_ready = 1'b1; mem_q = rsp; mem_q_burst = mk_burst(rsp); ready_cyc = cyc;
        end
      end
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        mem_ready = 1'b1; mem_q = 32'h0BADF00D; mem_q_burst = mk_burst(32'h0BADF00D);
        ready_cyc = cyc;
      end
      if ((mem_rd || mem_wr) && mem_addr != BAD) begin
        cd  = LAT;
        rsp = (mem_addr == 31'h40) ? 32'hDEADBEEF : {16'hC0DE, mem_addr[15:0]};
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses the memory port or acks a client.
  initial begin
    logic prev_pulse;
    iss_t ei;
    ack_t ea;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        chk("pulse_exclusive", 128'(mem_rd & mem_wr), 128'(0));
        chk("pulse_gap", 128'(prev_pulse), 128'(0));
        issue_cyc = cyc;
        if (issq.size() == 0) chk("unexpected_issue", 128'(1), 128'(0));
        else begin
          ei = issq.pop_front();
          chk("iss_we", 128'(mem_wr), 128'(ei.we));
          chk("iss_addr", 128'(mem_addr), 128'(ei.addr));
          chk("iss_data", 128'(mem_data), 128'(ei.data));
          chk("iss_be", 128'(mem_be), 128'(ei.be));
        end
      end
      prev_pulse = mem_rd | mem_wr;
      if (client_ack != '0) begin
        if (ackq.size() == 0) chk("unexpected_ack", 128'(client_ack), 128'(0));
        else begin
          ea = ackq.pop_front();
          chk("ack_onehot", 128'(client_ack), 128'(1) << ea.cl);
          chk("ack_err", 128'(client_err), 128'(ea.err));
          chk("ack_q", 128'(client_q[ea.cl]), 128'(ea.q));
          chk("ack_burst", client_q_burst[ea.cl], ea.burst);
          if (ea.err) chk("timeout_latency", 128'(cyc - issue_cyc), 128'(TMO + 2));
          else        chk("ack_latency", 128'(cyc - ready_cyc), 128'(1));
        end
      end else if (client_err) begin
        chk("err_without_ack", 128'(client_err), 128'(0));
      end
    end
  end

  initial begin
    logic seen;
    for (int i = 0; i < N; i++) begin target[i] = 0; done[i] = 0; end
    client_we = '0; client_addr = '0; client_data = '0; client_be = '0;
    reset = 1'b1; mem_available = 1'b1;

    // Reset state
    step(3);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ack", 128'(client_ack), 128'(0));
    chk("rst_err", 128'(client_err), 128'(0));
    chk("rst_pulse", 128'({mem_rd, mem_wr}), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_client_q", 128'(client_q), 128'(0));
    reset = 1'b0;
    step(2);

    // 1: single read, mem_rd one cycle after req is seen
    set_client(1, 1'b0, 31'h40, 32'h0, 4'hF);
    push_iss(1);
    push_ack(1, 1'b0, 32'hDEADBEEF, mk_burst(32'hDEADBEEF));
    target[1]++;
    step(1);
    chk("t1_req_up", 128'(client_req[1]), 128'(1));
    chk("t1_idle_no_pulse", 128'(mem_rd), 128'(0));
    step(1);
    chk("t1_rd_latency", 128'(mem_rd), 128'(1));
    wait_done(100, "t1_done");

    // 2: write, client_q of the writer stays at its reset value
    set_client(0, 1'b1, 31'h80, 32'h12345678, 4'b0011);
    push_iss(0);
    push_ack(0, 1'b0, 32'h0, '0);
    target[0]++;
    wait_done(100, "t2_done");

    // 3: all four clients, two requests each, from a fresh reset
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < N; i++)
      set_client(i, (i % 2) == 0, 31'((i + 1) * 256), 32'h11111111 * (i + 1), 4'hF);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        push_iss(i);
        if (i % 2 == 1) push_ack(i, 1'b0, {16'hC0DE, 16'((i + 1) * 256)},
                                 mk_burst({16'hC0DE, 16'((i + 1) * 256)}));
        else            push_ack(i, 1'b0, 32'h0, '0);
      end
    for (int i = 0; i < N; i++) target[i] += 2;
    wait_done(300, "t3_done");

    // 4: mem_available low holds off the issue
    mem_available = 1'b0;
    set_client(1, 1'b0, 31'h44, 32'h0, 4'hF);
    push_iss(1);
    push_ack(1, 1'b0, 32'hC0DE0044, mk_burst(32'hC0DE0044));
    target[1]++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen = seen | mem_rd | mem_wr | busy;
    end
    chk("t4_held_off", 128'(seen), 128'(0));
    mem_available = 1'b1;
    step(1);
    chk("t4_issue_after_avail", 128'(mem_rd), 128'(1));
    wait_done(100, "t4_done");

    // 5: client 2 never gets mem_ready and times out; client 3 is served after it
    set_client(2, 1'b0, BAD, 32'h0, 4'hF);
    set_client(3, 1'b1, 31'h500, 32'h55AA55AA, 4'hF);
    push_iss(2);
    push_ack(2, 1'b1, 32'h0, '0);
    push_iss(3);
    push_ack(3, 1'b0, 32'hC0DE0400, mk_burst(32'hC0DE0400));
    target[2]++;
    target[3]++;
    wait_done(3000, "t5_done");

    // 6: reset during WAIT, stray mem_ready afterwards, arbitration restarts at client 0
    set_client(2, 1'b0, BAD, 32'h0, 4'hF);
    push_iss(2);
    target[2]++;
    step(10);
    chk("t6_busy_in_wait", 128'(busy), 128'(1));
    target[2] = done[2];
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    chk("t6_busy_after_reset", 128'(busy), 128'(0));
    chk("t6_q_cleared", 128'(client_q), 128'(0));
    stray_req++;
    step(5);
    chk("t6_stray_ignored", 128'({busy, client_ack}), 128'(0));
    set_client(0, 1'b0, 31'h10, 32'h0, 4'hF);
    set_client(3, 1'b1, 31'h20, 32'hA1B2C3D4, 4'b1010);
    push_iss(0);
    push_ack(0, 1'b0, 32'hC0DE0010, mk_burst(32'hC0DE0010));
    push_iss(3);
    push_ack(3, 1'b0, 32'h0, '0);
    target[0]++;
    target[3]++;
    wait_done(200, "t6_done");

    step(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
